// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops a one-cycle-latency FIFO into a valid/ready stream through a 3-entry prefetch buffer.
// Optional delivered-word counter is enabled by defining FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  srst,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_mty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [31:0]           word_cnt
);

  logic [DATA_WIDTH-1:0] buf_mem [3];
  logic [1:0]            wptr;
  logic [1:0]            rptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic [2:0]            fill;
  logic                  capture;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign fill = {1'b0, occ} + {2'b0, inflight};

  // Issue uses registered state only, so out_ready never reaches fifo_rd combinationally.
  assign fifo_rd   = !arst && !srst && !fifo_mty && (fill < 3'd3);
  assign capture   = inflight && !srst;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && out_ready && !srst;
  assign out_data  = buf_mem[rptr];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < 3; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (capture) begin
      buf_mem[wptr] <= fifo_q;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wptr     <= 2'd0;
      rptr     <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else if (srst) begin
      // A word returning this cycle is dropped; the FIFO itself is left untouched.
      wptr     <= 2'd0;
      rptr     <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (capture) begin
        wptr <= ptr_inc(wptr);
      end
      if (pop) begin
        rptr <= ptr_inc(rptr);
      end
      if (capture && !pop) begin
        occ <= occ + 2'd1;
      end else if (pop && !capture) begin
        occ <= occ - 2'd1;
      end
    end
  end

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0] cnt_reg;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_reg <= 32'd0;
    end else if (srst) begin
      cnt_reg <= 32'd0;
    end else if (pop) begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  assign word_cnt = cnt_reg;
`else
  assign word_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a cycle-stepped model of the attached one-cycle-latency FIFO.
module tb_fifo_stream_reader;
  localparam int W = 32;

  logic         clk;
  logic         arst;
  logic         srst;
  logic         fifo_rd;
  logic [W-1:0] fifo_q;
  logic         fifo_mty;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [31:0]  word_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fmem [256];
  int fhead, ftail;
  logic [W-1:0] got [$];
  int got_cyc [$];
  int cyc, rd_count, first_rd, first_valid;

  fifo_stream_reader #(.DATA_WIDTH(W)) dut (
    .clk(clk), .arst(arst), .srst(srst),
    .fifo_rd(fifo_rd), .fifo_q(fifo_q), .fifo_mty(fifo_mty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .word_cnt(word_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Entered 1 time unit after a rising edge; samples at the falling edge, advances the FIFO model after the next rising edge.
  task automatic tick();
    logic rd_s, pop_s;
    logic [W-1:0] d_s;
    #4;
    rd_s  = fifo_rd;
    pop_s = out_valid && out_ready;
    d_s   = out_data;
    checks++;
    if (rd_s !== 1'b0 && fifo_mty !== 1'b0) begin
      errors++;
      $display("FAIL rd_while_mty cycle %0d: fifo_rd=%b with fifo_mty=%b, required fifo_rd=0", cyc, rd_s, fifo_mty);
    end
    if (rd_s === 1'b1) begin
      rd_count++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (pop_s === 1'b1) begin
      got.push_back(d_s);
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (rd_s === 1'b1 && fhead != ftail) begin
      fifo_q = fmem[fhead];
      fhead++;
    end
    fifo_mty = (fhead == ftail);
    cyc++;
  endtask

  task automatic preload(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fmem[ftail] = W'(base + i);
      ftail++;
    end
    fifo_mty = (fhead == ftail);
  endtask

  task automatic apply_arst();
    arst = 1'b1; srst = 1'b0; out_ready = 1'b0;
    fhead = 0; ftail = 0; fifo_mty = 1'b1; fifo_q = '0;
    @(posedge clk);
    #1;
    arst = 1'b0;
    got.delete(); got_cyc.delete();
    cyc = 0; rd_count = 0; first_rd = -1; first_valid = -1;
  endtask

  task automatic test_reset();
    apply_arst();
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (fifo_rd !== 1'b0) begin errors++; $display("FAIL idle_fifo_rd cycle %0d: got %b required 0", c, fifo_rd); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid cycle %0d: got %b required 0", c, out_valid); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL idle_out_data cycle %0d: got %h required 0", c, out_data); end
      checks++;
      if (word_cnt !== 32'd0) begin errors++; $display("FAIL idle_word_cnt cycle %0d: got %h required 0", c, word_cnt); end
    end
  endtask

  task automatic test_streaming();
    apply_arst();
    preload(16, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got.size() < 16; c++) tick();
    checks++;
    if (got.size() != 16) begin errors++; $display("FAIL stream_count: got %0d words required 16", got.size()); end
    checks++;
    if (first_valid - first_rd != 2) begin
      errors++; $display("FAIL stream_latency: out_valid %0d cycles after first fifo_rd, required 2", first_valid - first_rd);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h required %h", i, got[i], W'(i)); end
      checks++;
      if (got_cyc[i] != got_cyc[0] + i) begin
        errors++; $display("FAIL stream_gap[%0d]: delivered cycle %0d required %0d", i, got_cyc[i], got_cyc[0] + i);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_arst();
    preload(8, 0);
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL bp_hold_data cycle %0d: got %h required 0", c, out_data); end
    end
    checks++;
    if (rd_count != 3) begin errors++; $display("FAIL bp_rd_pulses: got %0d required 3", rd_count); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b required 1", out_valid); end
    for (int c = 0; c < 200 && got.size() < 8; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (got.size() != 8) begin errors++; $display("FAIL bp_count: got %0d words required 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(i)) begin errors++; $display("FAIL bp_data[%0d]: got %h required %h", i, got[i], W'(i)); end
    end
  endtask

  task automatic test_srst();
    apply_arst();
    preload(10, 100);
    out_ready = 1'b0;
    // Three reads issued: two words buffered and one in flight when srst hits.
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (rd_count != 3) begin errors++; $display("FAIL srst_setup_rd: got %0d required 3", rd_count); end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL srst_out_valid: got %b required 0", out_valid); end
    checks++;
    if (word_cnt !== 32'd0) begin errors++; $display("FAIL srst_word_cnt: got %h required 0", word_cnt); end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got.size() < 7; c++) tick();
    out_ready = 1'b0;
    checks++;
    if (got.size() != 7) begin errors++; $display("FAIL srst_count: got %0d words required 7", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(103 + i)) begin errors++; $display("FAIL srst_data[%0d]: got %h required %h", i, got[i], W'(103 + i)); end
    end
  endtask

  task automatic test_arst_mid();
    apply_arst();
    preload(5, 50);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== W'(50)) begin
      errors++; $display("FAIL arst_setup: valid=%b data=%h required valid=1 data=%h", out_valid, out_data, W'(50));
    end
    fhead = 0; ftail = 5; fifo_mty = 1'b0;
    arst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b required 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL arst_out_data: got %h required 0", out_data); end
    checks++;
    if (fifo_rd !== 1'b0) begin errors++; $display("FAIL arst_fifo_rd: got %b required 0", fifo_rd); end
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic test_counter();
    apply_arst();
    preload(100, 1000);
    out_ready = 1'b1;
    for (int c = 0; c < 300 && got.size() < 100; c++) tick();
    out_ready = 1'b0;
    checks++;
    if (got.size() != 100) begin errors++; $display("FAIL cnt_words: got %0d required 100", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(1000 + i)) begin errors++; $display("FAIL cnt_data[%0d]: got %h required %h", i, got[i], W'(1000 + i)); end
    end
    checks++;
`ifdef FIFO_STREAM_READER_CNT_EN
    if (word_cnt !== 32'd100) begin errors++; $display("FAIL cnt_value: got %0d required 100", word_cnt); end
`else
    if (word_cnt !== 32'd0) begin errors++; $display("FAIL cnt_disabled: got %0d required 0", word_cnt); end
`endif
  endtask

`ifdef FIFO_STREAM_READER_CNT_EN
  task automatic test_counter_wrap();
    logic [31:0] exp_cnt [3];
    exp_cnt[0] = 32'hFFFF_FFFF;
    exp_cnt[1] = 32'h0000_0000;
    exp_cnt[2] = 32'h0000_0001;
    apply_arst();
    preload(3, 7);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    force dut.cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_reg;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (word_cnt !== exp_cnt[i]) begin errors++; $display("FAIL cnt_wrap[%0d]: got %h required %h", i, word_cnt, exp_cnt[i]); end
    end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    arst = 1'b1; srst = 1'b0; out_ready = 1'b0; fifo_mty = 1'b1; fifo_q = '0;
    fhead = 0; ftail = 0; cyc = 0; rd_count = 0; first_rd = -1; first_valid = -1;
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_srst();
    test_arst_mid();
    test_counter();
`ifdef FIFO_STREAM_READER_CNT_EN
    test_counter_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
